jtag_tap_resp: RTL
==================

# jtag_tap_resp

- Target-side JTAG TAP responder: the counterpart of the board-level JTAG stimulus generator.
- Consumes `trstn`/`tms`/`tdi` sampled on `jtag_clk_i` and runs the IEEE 1149.1 16-state TAP controller.
- Implements an instruction register plus IDCODE, BYPASS and a debug (DBG) data register, and drives `tdo`.
- Completed DBG updates are presented to downstream debug logic as a one-cycle strobe.

## Interface
Parameters:
- `IR_WIDTH`, 4, instruction register width.
- `DBG_WIDTH`, 53, DBG shift-register width ({cmd[4:0], addr[31:0], len[15:0]}).
- `IDCODE_VAL`, 32'h249511C3, value captured by IDCODE.

Ports:
- `jtag_clk_i` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `trstn` in 1: JTAG test reset, active-low, sampled synchronously.
- `tms` in 1: mode select, sampled each rising edge.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out.
- `tap_state_o` out 4: current TAP state (package encoding).
- `ir_o` out IR_WIDTH: latched instruction.
- `dbg_capture_i` in DBG_WIDTH: value loaded into DBG on Capture-DR.
- `dbg_data_o` out DBG_WIDTH: last updated DBG value.
- `dbg_update_o` out 1: one-cycle pulse when DBG is updated.

## Operation
- **States:** TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR. Transitions follow standard 1149.1 on `tms`.
- **TAP reset:**
  - `trstn`=0 at a rising edge: state←TLR, ir←IDCODE, all shift registers cleared. This overrides `tms`.
  - In TLR, ir is held at IDCODE.
- **Instructions:** 4'h0 DBG, 4'h1 IDCODE, 4'hF BYPASS. Any other code selects BYPASS.
- **IR path:**
  - CAP_IR: ir_sr←4'b0101.
  - SH_IR: ir_sr←{tdi, ir_sr[IR_WIDTH-1:1]}.
  - UPD_IR: ir←ir_sr.
- **DR path:** the selected register is fixed by `ir`.
  - CAP_DR: IDCODE sr←IDCODE_VAL; BYPASS bit←0; DBG sr←`dbg_capture_i`.
  - SH_DR: selected register shifts right, tdi entering the MSB (BYPASS is 1 bit).
  - UPD_DR with ir=DBG: `dbg_data_o`←DBG sr and `dbg_update_o`=1 for exactly that cycle. UPD_DR with any other instruction produces no strobe.
- **Shift edges:**
  - Shifting occurs on every rising edge at which the state is SH_*, including the exit edge (tms=1). Each scan therefore shifts N bits for N edges spent in SH_*.
  - Pause states hold shift-register contents.
- **tdo:**
  - Combinational: ir_sr[0] in SH_IR, selected DR sr[0] in SH_DR, otherwise 0.
  - The first tdo bit is therefore valid in the cycle after the CAP→SH transition.
- **Non-selected registers:** never shift.

## Timing
- Reset values (`rst_n`=0, asynchronous):
  - state TLR, ir 4'h1, all shift registers 0.
  - `tdo`=0, `dbg_data_o`=0, `dbg_update_o`=0, `tap_state_o`=TLR encoding.
- `tap_state_o` is the registered state with zero added latency.
- Latency from the `tms` edge entering UPD_DR to the `dbg_update_o` pulse: the pulse is asserted during the UPD_DR cycle and registered on the edge leaving it. `dbg_data_o` is stable from the following cycle.
- `rst_n` or `trstn` asserted mid-scan: the scan is discarded, with no update strobe and `dbg_data_o` unchanged except by `rst_n`.
- Five consecutive `tms`=1 edges reach TLR from any state.
- Simultaneous `trstn`=0 and UPD_DR: reset wins, with no strobe.

## Structure
- Package `jtag_pkg`:
  - `tap_state_e` (4-bit enum, TLR=4'hF, RTI=4'hC, others per 1149.1 encoding).
  - Instruction constants `INSTR_DBG`, `INSTR_IDCODE`, `INSTR_BYPASS`.
  - `IR_CAPTURE` = 4'b0101.
- Sub-module `jtag_tap_fsm`: state register and next-state logic only. Inputs are `tms` and `trstn`; outputs are the state plus decoded capture, shift and update strobes for IR and DR.
- The top level holds the IR, IDCODE, BYPASS and DBG registers and the tdo mux.

## Test plan
- **Reset and IDCODE:** `rst_n` pulse, then TLR→RTI→SEL_DR→CAP_DR and 32 SH_DR edges → `tdo` serial stream LSB-first equals 32'h249511C3.
- **BYPASS:**
  - Load IR=4'hF; confirm IR shift-out reads 4'b0101.
  - Shift DR with tdi pattern 1,0,1,1 → tdo 0,1,0,1, i.e. one edge delay with a leading 0.
- **DBG write:**
  - Load IR=4'h0, `dbg_capture_i`=53'h0.
  - Shift {5'h3, 32'h1A107008, 16'h0001} in 53 edges, then UPD_DR.
  - Expect `dbg_data_o`=that value and a single-cycle `dbg_update_o`; tdo emits 0s during the shift.
- **DBG with pause:** same write with 10 cycles in PAU_DR midway → identical `dbg_data_o`, exactly one strobe.
- **trstn mid-shift:**
  - Assert `trstn`=0 for 1 cycle at DBG bit 20 → state TLR, `ir_o`=4'h1, no strobe, `dbg_data_o` unchanged.
  - Repeat with `rst_n` → all outputs at reset values immediately, without waiting for a clock edge.
- **Unknown instruction:** IR=4'h7 → behaves as BYPASS; UPD_DR produces no `dbg_update_o`.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP state encoding and instruction codes for the JTAG responder.
package jtag_pkg;

   // IEEE 1149.1 conventional state encoding
   typedef enum logic [3:0] {
      EX2_DR = 4'h0,
      EX1_DR = 4'h1,
      SH_DR  = 4'h2,
      PAU_DR = 4'h3,
      SEL_IR = 4'h4,
      UPD_DR = 4'h5,
      CAP_DR = 4'h6,
      SEL_DR = 4'h7,
      EX2_IR = 4'h8,
      EX1_IR = 4'h9,
      SH_IR  = 4'hA,
      PAU_IR = 4'hB,
      RTI    = 4'hC,
      UPD_IR = 4'hD,
      CAP_IR = 4'hE,
      TLR    = 4'hF
   } tap_state_e;

   localparam logic [3:0] INSTR_DBG    = 4'h0;
   localparam logic [3:0] INSTR_IDCODE = 4'h1;
   localparam logic [3:0] INSTR_BYPASS = 4'hF;
   localparam logic [3:0] IR_CAPTURE   = 4'b0101;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register, next-state logic and decoded
// capture/shift/update strobes for the IR and DR paths.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       jtag_clk_i,
   input  logic       rst_n,
   input  logic       trstn,
   input  logic       tms,
   output tap_state_e o_state,
   output logic       o_tlr,
   output logic       o_capture_dr,
   output logic       o_shift_dr,
   output logic       o_update_dr,
   output logic       o_capture_ir,
   output logic       o_shift_ir,
   output logic       o_update_ir
);

   tap_state_e r_state;
   tap_state_e w_next;

   // Test reset is synchronous and overrides tms
   always_ff @(posedge jtag_clk_i or negedge rst_n) begin
      if (!rst_n)
         r_state <= TLR;
      else if (!trstn)
         r_state <= TLR;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         TLR:    w_next = tms ? TLR    : RTI;
         RTI:    w_next = tms ? SEL_DR : RTI;
         SEL_DR: w_next = tms ? SEL_IR : CAP_DR;
         CAP_DR: w_next = tms ? EX1_DR : SH_DR;
         SH_DR:  w_next = tms ? EX1_DR : SH_DR;
         EX1_DR: w_next = tms ? UPD_DR : PAU_DR;
         PAU_DR: w_next = tms ? EX2_DR : PAU_DR;
         EX2_DR: w_next = tms ? UPD_DR : SH_DR;
         UPD_DR: w_next = tms ? SEL_DR : RTI;
         SEL_IR: w_next = tms ? TLR    : CAP_IR;
         CAP_IR: w_next = tms ? EX1_IR : SH_IR;
         SH_IR:  w_next = tms ? EX1_IR : SH_IR;
         EX1_IR: w_next = tms ? UPD_IR : PAU_IR;
         PAU_IR: w_next = tms ? EX2_IR : PAU_IR;
         EX2_IR: w_next = tms ? UPD_IR : SH_IR;
         UPD_IR: w_next = tms ? SEL_DR : RTI;
      endcase
   end

   assign o_state      = r_state;
   assign o_tlr        = (r_state == TLR);
   assign o_capture_dr = (r_state == CAP_DR);
   assign o_shift_dr   = (r_state == SH_DR);
   assign o_update_dr  = (r_state == UPD_DR);
   assign o_capture_ir = (r_state == CAP_IR);
   assign o_shift_ir   = (r_state == SH_IR);
   assign o_update_ir  = (r_state == UPD_IR);

endmodule

// File: rtl/jtag_tap_resp.sv
// Target-side JTAG TAP responder: instruction register plus IDCODE, BYPASS
// and DBG data registers, with a one-cycle strobe on each DBG update.
module jtag_tap_resp
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH   = 4,
   parameter int          DBG_WIDTH  = 53,
   parameter logic [31:0] IDCODE_VAL = 32'h249511C3
)(
   input  logic                 jtag_clk_i,
   input  logic                 rst_n,
   input  logic                 trstn,
   input  logic                 tms,
   input  logic                 tdi,
   output logic                 tdo,
   output logic [3:0]           tap_state_o,
   output logic [IR_WIDTH-1:0]  ir_o,
   input  logic [DBG_WIDTH-1:0] dbg_capture_i,
   output logic [DBG_WIDTH-1:0] dbg_data_o,
   output logic                 dbg_update_o
);

   tap_state_e w_state;
   logic w_tlr, w_cap_dr, w_sh_dr, w_upd_dr, w_cap_ir, w_sh_ir, w_upd_ir;
   logic w_sel_dbg, w_sel_idcode;
   logic w_tdo;

   logic [IR_WIDTH-1:0]  r_ir;
   logic [IR_WIDTH-1:0]  r_ir_sr;
   logic [31:0]          r_idcode_sr;
   logic                 r_bypass;
   logic [DBG_WIDTH-1:0] r_dbg_sr;
   logic [DBG_WIDTH-1:0] r_dbg_data;

   jtag_tap_fsm u_fsm (
      .jtag_clk_i   (jtag_clk_i),
      .rst_n        (rst_n),
      .trstn        (trstn),
      .tms          (tms),
      .o_state      (w_state),
      .o_tlr        (w_tlr),
      .o_capture_dr (w_cap_dr),
      .o_shift_dr   (w_sh_dr),
      .o_update_dr  (w_upd_dr),
      .o_capture_ir (w_cap_ir),
      .o_shift_ir   (w_sh_ir),
      .o_update_ir  (w_upd_ir)
   );

   // Unrecognised codes fall through to BYPASS
   assign w_sel_dbg    = (r_ir == IR_WIDTH'(INSTR_DBG));
   assign w_sel_idcode = (r_ir == IR_WIDTH'(INSTR_IDCODE));

   always_ff @(posedge jtag_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_ir    <= IR_WIDTH'(INSTR_IDCODE);
         r_ir_sr <= '0;
      end else if (!trstn) begin
         r_ir    <= IR_WIDTH'(INSTR_IDCODE);
         r_ir_sr <= '0;
      end else begin
         if (w_cap_ir)
            r_ir_sr <= IR_WIDTH'(IR_CAPTURE);
         else if (w_sh_ir)
            r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
         if (w_tlr)
            r_ir <= IR_WIDTH'(INSTR_IDCODE);
         else if (w_upd_ir)
            r_ir <= r_ir_sr;
      end
   end

   always_ff @(posedge jtag_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_idcode_sr <= '0;
         r_bypass    <= 1'b0;
         r_dbg_sr    <= '0;
      end else if (!trstn) begin
         r_idcode_sr <= '0;
         r_bypass    <= 1'b0;
         r_dbg_sr    <= '0;
      end else if (w_cap_dr) begin
         r_idcode_sr <= IDCODE_VAL;
         r_bypass    <= 1'b0;
         r_dbg_sr    <= dbg_capture_i;
      end else if (w_sh_dr) begin
         if (w_sel_dbg)
            r_dbg_sr <= {tdi, r_dbg_sr[DBG_WIDTH-1:1]};
         else if (w_sel_idcode)
            r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
         else
            r_bypass <= tdi;
      end
   end

   // A test reset in the update cycle discards the scan
   always_ff @(posedge jtag_clk_i or negedge rst_n) begin
      if (!rst_n)
         r_dbg_data <= '0;
      else if (trstn && w_upd_dr && w_sel_dbg)
         r_dbg_data <= r_dbg_sr;
   end

   always_comb begin
      w_tdo = 1'b0;
      if (w_sh_ir)
         w_tdo = r_ir_sr[0];
      else if (w_sh_dr) begin
         if (w_sel_dbg)
            w_tdo = r_dbg_sr[0];
         else if (w_sel_idcode)
            w_tdo = r_idcode_sr[0];
         else
            w_tdo = r_bypass;
      end
   end

   assign tdo          = w_tdo;
   assign tap_state_o  = w_state;
   assign ir_o         = r_ir;
   assign dbg_data_o   = r_dbg_data;
   assign dbg_update_o = w_upd_dr & w_sel_dbg & trstn;

endmodule
